// File: rtl/segre_dcache_ctrl.sv
// segre_dcache_ctrl: sequencer/arbiter for the single dcache data-array port.
// Three requesters share the port: MMU line fill, MEM-stage load and
// store-buffer drain. Stalls the pipeline on a load miss, issues the MMU line
// read, writes the returned line and replays the load.
// Ports:
//   clk_i, rsn_i             clock, async active-low reset
//   ld_req_i/ld_addr_i/ld_hit_i  MEM-stage load and same-cycle tag result
//   kill_i                   pipeline flush, kills the outstanding load
//   sb_req_i/sb_full_i       store buffer has an entry / is full
//   mmu_rd_ack_i             MMU accepted the line read
//   mmu_data_rdy_i           fill line valid (1-cycle pulse)
//   arb_sel_o                array owner: 0 none, 1 load, 2 store, 3 fill
//   sb_gnt_o                 store drain granted (SB pops)
//   fill_we_o                write fill line + tag
//   stall_o                  freeze IF..MEM
//   mmu_rd_req_o/mmu_rd_addr_o  line-read request and line-aligned address
module segre_dcache_ctrl #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned LANE_BYTES    = 16,
  parameter int unsigned SB_STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic              ld_hit_i,
  input  logic              kill_i,
  input  logic              sb_req_i,
  input  logic              sb_full_i,
  input  logic              mmu_rd_ack_i,
  input  logic              mmu_data_rdy_i,
  output logic [1:0]        arb_sel_o,
  output logic              sb_gnt_o,
  output logic              fill_we_o,
  output logic              stall_o,
  output logic              mmu_rd_req_o,
  output logic [ADDR_W-1:0] mmu_rd_addr_o
);

  localparam int unsigned STARVE_W = $clog2(SB_STARVE_MAX + 1);

  localparam logic [1:0]          SEL_NONE     = 2'd0;
  localparam logic [1:0]          SEL_LOAD     = 2'd1;
  localparam logic [1:0]          SEL_STORE    = 2'd2;
  localparam logic [1:0]          SEL_FILL     = 2'd3;
  localparam logic [ADDR_W-1:0]   LINE_MASK    = ADDR_W'(LANE_BYTES - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(SB_STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    REPLAY
  } state_e;

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic                killed_q, killed_d;

  logic                forced_st;
  logic                ld_go;
  logic [STARVE_W-1:0] starve_inc;

  // A pending store wins over loads when the buffer is full or loads have
  // won SB_STARVE_MAX times in a row.
  assign forced_st  = sb_req_i & (sb_full_i | (starve_q == STARVE_LIMIT));
  assign ld_go      = ld_req_i & ~kill_i;
  assign starve_inc = (starve_q == STARVE_LIMIT) ? starve_q : starve_q + STARVE_W'(1);

  // State and bookkeeping registers
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      miss_addr_q <= '0;
      killed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      miss_addr_q <= miss_addr_d;
      killed_q    <= killed_d;
    end
  end

  // Next-state and bookkeeping updates
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    miss_addr_d = miss_addr_q;
    killed_d    = killed_q;
    unique case (state_q)
      IDLE: begin
        if (forced_st) begin
          starve_d = '0;
        end else if (ld_go) begin
          if (ld_hit_i) begin
            starve_d = sb_req_i ? starve_inc : '0;
          end else begin
            miss_addr_d = ld_addr_i & ~LINE_MASK;
            killed_d    = 1'b0;
            state_d     = MISS_REQ;
          end
        end else begin
          // either a plain drain or nothing pending: no starvation either way
          starve_d = '0;
        end
      end
      MISS_REQ: begin
        // a kill before acceptance abandons the miss; the request drops now
        if (kill_i) begin
          state_d = IDLE;
        end else if (mmu_rd_ack_i) begin
          state_d = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        // the MMU cannot abort, so a kill here only suppresses the replay
        if (kill_i) begin
          killed_d = 1'b1;
        end
        if (mmu_data_rdy_i) begin
          state_d = FILL;
        end else if (sb_req_i) begin
          starve_d = '0;
        end
      end
      FILL: begin
        state_d = (killed_q | kill_i) ? IDLE : REPLAY;
      end
      REPLAY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port select, grants, stall and MMU request for the current cycle
  always_comb begin
    arb_sel_o     = SEL_NONE;
    sb_gnt_o      = 1'b0;
    fill_we_o     = 1'b0;
    stall_o       = 1'b0;
    mmu_rd_req_o  = 1'b0;
    mmu_rd_addr_o = '0;
    if (rsn_i) begin
      mmu_rd_addr_o = miss_addr_q;
      unique case (state_q)
        IDLE: begin
          if (forced_st) begin
            arb_sel_o = SEL_STORE;
            sb_gnt_o  = 1'b1;
            stall_o   = ld_req_i;
          end else if (ld_go) begin
            arb_sel_o = SEL_LOAD;
            stall_o   = ~ld_hit_i;
          end else if (sb_req_i) begin
            arb_sel_o = SEL_STORE;
            sb_gnt_o  = 1'b1;
          end
        end
        MISS_REQ: begin
          stall_o      = 1'b1;
          mmu_rd_req_o = ~kill_i;
        end
        MISS_WAIT: begin
          stall_o = 1'b1;
          if (mmu_data_rdy_i) begin
            arb_sel_o = SEL_FILL;
            fill_we_o = 1'b1;
          end else if (sb_req_i) begin
            arb_sel_o = SEL_STORE;
            sb_gnt_o  = 1'b1;
          end
        end
        FILL: begin
          // port left idle so a drain cannot collide with the fill write
          stall_o = 1'b1;
        end
        REPLAY: begin
          arb_sel_o = SEL_LOAD;
        end
        default: begin
          arb_sel_o = SEL_NONE;
        end
      endcase
    end
  end

  // Fill data outside MISS_WAIT is a protocol error and is otherwise ignored
  a_rdy_in_wait: assert property (@(posedge clk_i) disable iff (!rsn_i)
    mmu_data_rdy_i |-> (state_q == MISS_WAIT));

  a_gnt_is_store: assert property (@(posedge clk_i) disable iff (!rsn_i)
    sb_gnt_o |-> (arb_sel_o == SEL_STORE));

endmodule

// File: tb/tb_segre_dcache_ctrl.sv
// Testbench for segre_dcache_ctrl: directed scenarios followed by random
// traffic. The driver computes the expected per-cycle response from a
// transaction-level model and queues it; a monitor pops and compares.
module tb_segre_dcache_ctrl;

  localparam int unsigned LANE   = 16;
  localparam int unsigned SMAX   = 4;
  localparam int unsigned NRAND  = 3000;

  typedef struct packed {
    logic        rsn;
    logic        ld_req;
    logic [31:0] addr;
    logic        hit;
    logic        kill;
    logic        sb_req;
    logic        sb_full;
    logic        ack;
    logic        rdy;
  } in_t;

  typedef struct packed {
    logic [1:0]  arb;
    logic        gnt;
    logic        we;
    logic        stall;
    logic        req;
    logic [31:0] addr;
  } exp_t;

  logic        clk;
  logic        rsn_i;
  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic        ld_hit_i;
  logic        kill_i;
  logic        sb_req_i;
  logic        sb_full_i;
  logic        mmu_rd_ack_i;
  logic        mmu_data_rdy_i;
  logic [1:0]  arb_sel_o;
  logic        sb_gnt_o;
  logic        fill_we_o;
  logic        stall_o;
  logic        mmu_rd_req_o;
  logic [31:0] mmu_rd_addr_o;

  segre_dcache_ctrl #(
    .ADDR_W        (32),
    .LANE_BYTES    (LANE),
    .SB_STARVE_MAX (SMAX)
  ) dut (
    .clk_i          (clk),
    .rsn_i          (rsn_i),
    .ld_req_i       (ld_req_i),
    .ld_addr_i      (ld_addr_i),
    .ld_hit_i       (ld_hit_i),
    .kill_i         (kill_i),
    .sb_req_i       (sb_req_i),
    .sb_full_i      (sb_full_i),
    .mmu_rd_ack_i   (mmu_rd_ack_i),
    .mmu_data_rdy_i (mmu_data_rdy_i),
    .arb_sel_o      (arb_sel_o),
    .sb_gnt_o       (sb_gnt_o),
    .fill_we_o      (fill_we_o),
    .stall_o        (stall_o),
    .mmu_rd_req_o   (mmu_rd_req_o),
    .mmu_rd_addr_o  (mmu_rd_addr_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  // Reference model: a miss is a transaction moving through its phases
  bit          m_await_ack;
  bit          m_await_data;
  bit          m_fill;
  bit          m_replay;
  bit          m_killed;
  int unsigned m_starve;
  logic [31:0] m_line;

  task automatic model_reset();
    m_await_ack  = 1'b0;
    m_await_data = 1'b0;
    m_fill       = 1'b0;
    m_replay     = 1'b0;
    m_killed     = 1'b0;
    m_starve     = 0;
    m_line       = '0;
  endtask

  // Apply one cycle of inputs just after the clock edge and queue the expectation
  task automatic tick(input in_t v);
    exp_t e;
    bit   force_store;
    @(posedge clk);
    #1;
    rsn_i          = v.rsn;
    ld_req_i       = v.ld_req;
    ld_addr_i      = v.addr;
    ld_hit_i       = v.hit;
    kill_i         = v.kill;
    sb_req_i       = v.sb_req;
    sb_full_i      = v.sb_full;
    mmu_rd_ack_i   = v.ack;
    mmu_data_rdy_i = v.rdy;
    e = '0;
    if (!v.rsn) begin
      model_reset();
    end else if (m_await_ack) begin
      e.stall = 1'b1;
      if (v.kill) begin
        m_await_ack = 1'b0;
      end else begin
        e.req  = 1'b1;
        e.addr = m_line;
        if (v.ack) begin
          m_await_ack  = 1'b0;
          m_await_data = 1'b1;
        end
      end
    end else if (m_await_data) begin
      e.stall = 1'b1;
      if (v.kill) m_killed = 1'b1;
      if (v.rdy) begin
        e.arb = 2'd3;
        e.we  = 1'b1;
        m_await_data = 1'b0;
        m_fill       = 1'b1;
      end else if (v.sb_req) begin
        e.arb    = 2'd2;
        e.gnt    = 1'b1;
        m_starve = 0;
      end
    end else if (m_fill) begin
      e.stall  = 1'b1;
      m_fill   = 1'b0;
      m_replay = !(m_killed || v.kill);
    end else if (m_replay) begin
      e.arb    = 2'd1;
      m_replay = 1'b0;
    end else begin
      force_store = v.sb_req && (v.sb_full || m_starve == SMAX);
      if (force_store) begin
        e.arb    = 2'd2;
        e.gnt    = 1'b1;
        e.stall  = v.ld_req;
        m_starve = 0;
      end else if (v.ld_req && !v.kill) begin
        e.arb = 2'd1;
        if (v.hit) begin
          m_starve = v.sb_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        end else begin
          e.stall     = 1'b1;
          m_line      = v.addr - (v.addr % LANE);
          m_killed    = 1'b0;
          m_await_ack = 1'b1;
        end
      end else begin
        if (v.sb_req) begin
          e.arb = 2'd2;
          e.gnt = 1'b1;
        end
        m_starve = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, want);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  exp_t cur;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        cyc++;
        cur = exp_q.pop_front();
        check("arb_sel", 32'(arb_sel_o), 32'(cur.arb));
        check("sb_gnt", 32'(sb_gnt_o), 32'(cur.gnt));
        check("fill_we", 32'(fill_we_o), 32'(cur.we));
        check("stall", 32'(stall_o), 32'(cur.stall));
        check("mmu_rd_req", 32'(mmu_rd_req_o), 32'(cur.req));
        if (cur.req) check("mmu_rd_addr", mmu_rd_addr_o, cur.addr);
      end
    end
  end

  in_t v;
  in_t base;

  initial begin
    rsn_i = 1'b0; ld_req_i = 1'b0; ld_addr_i = '0; ld_hit_i = 1'b0; kill_i = 1'b0;
    sb_req_i = 1'b0; sb_full_i = 1'b0; mmu_rd_ack_i = 1'b0; mmu_data_rdy_i = 1'b0;
    model_reset();
    base = '0;
    base.rsn = 1'b1;

    // reset held, then idle
    v = '0;
    tick(v); tick(v);
    v = base; tick(v);

    // load hit at 0x100 without store traffic
    v = base; v.ld_req = 1'b1; v.addr = 32'h100; v.hit = 1'b1; tick(v);
    v = base; tick(v);

    // load miss at 0x1234: ack after 3 request cycles, data 5 cycles later
    v = base; v.ld_req = 1'b1; v.addr = 32'h1234; tick(v);
    tick(v); tick(v);
    v.ack = 1'b1; tick(v); v.ack = 1'b0;
    repeat (4) tick(v);
    v.rdy = 1'b1; tick(v); v.rdy = 1'b0;
    v.hit = 1'b1; tick(v);
    tick(v);
    v = base; tick(v);

    // reset while waiting for fill data: no replay afterwards
    v = base; v.ld_req = 1'b1; v.addr = 32'hABCD; tick(v);
    v.ld_req = 1'b0; v.ack = 1'b1; tick(v); v.ack = 1'b0;
    tick(v); tick(v);
    v.rsn = 1'b0; v.ld_req = 1'b1; v.sb_req = 1'b1; tick(v);
    v = base; tick(v); tick(v);

    // starvation: four load wins then a forced drain; full buffer forces at once
    v = base; v.ld_req = 1'b1; v.hit = 1'b1; v.sb_req = 1'b1; v.addr = 32'h200;
    repeat (6) tick(v);
    v.sb_full = 1'b1; tick(v);
    v = base; tick(v);

    // kill before ack drops the request
    v = base; v.ld_req = 1'b1; v.addr = 32'h3008; tick(v);
    v.ld_req = 1'b0; tick(v);
    v.kill = 1'b1; tick(v);
    v = base; tick(v);

    // kill after ack: fill still happens, replay skipped
    v = base; v.ld_req = 1'b1; v.addr = 32'h4444; tick(v);
    v.ld_req = 1'b0; v.ack = 1'b1; tick(v); v.ack = 1'b0;
    v.kill = 1'b1; tick(v); v.kill = 1'b0;
    v.rdy = 1'b1; tick(v); v.rdy = 1'b0;
    tick(v); tick(v);

    // drains during the data wait; fill beats a simultaneous drain
    v = base; v.ld_req = 1'b1; v.addr = 32'h5555; tick(v);
    v.ld_req = 1'b0; v.ack = 1'b1; tick(v); v.ack = 1'b0;
    v.sb_req = 1'b1; repeat (3) tick(v);
    v.rdy = 1'b1; tick(v); v.rdy = 1'b0; v.sb_req = 1'b0;
    tick(v); tick(v); tick(v);

    // random traffic; ack/rdy only when the MMU protocol allows them
    for (int i = 0; i < NRAND; i++) begin
      v         = '0;
      v.rsn     = ($urandom_range(0, 399) != 0);
      v.ld_req  = ($urandom_range(0, 2) != 0);
      v.addr    = $urandom;
      v.hit     = ($urandom_range(0, 3) != 0);
      v.kill    = ($urandom_range(0, 11) == 0);
      v.sb_req  = ($urandom_range(0, 1) == 1);
      v.sb_full = ($urandom_range(0, 7) == 0);
      v.ack     = v.rsn && !v.kill && m_await_ack && ($urandom_range(0, 2) == 0);
      v.rdy     = v.rsn && m_await_data && ($urandom_range(0, 3) == 0);
      tick(v);
    end

    v = base; tick(v);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
